// File: rtl/a2d_spi_intf.sv
// SPI master for the 8-channel 12-bit A2D: frame 1 sends the channel, frame 2 returns the result.
// Latency: strt_cnv to cnv_cmplt is 1 + 520 + GAP_CLKS + 520 clks.
// Backpressure: none; strt_cnv is honoured only in IDLE and ignored otherwise.
module a2d_spi_intf #(
    parameter int GAP_CLKS = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strt_cnv,
    input  logic [2:0]  chnnl,
    output logic        cnv_cmplt,
    output logic [11:0] res,
    output logic        a2d_SS_n,
    output logic        SCLK,
    output logic        MOSI,
    input  logic        MISO
);

    localparam int GW = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [4:0] SCLK_RELOAD = 5'b10111;

    typedef enum logic [1:0] {IDLE, FRM1, GAP, FRM2} state_t;

    state_t         state_q, state_d;
    logic           ss_n_q, ss_n_d;
    logic [4:0]     sclk_div_q, sclk_div_d;
    logic [4:0]     bit_cnt_q, bit_cnt_d;
    logic [15:0]    shft_q, shft_d;
    logic           miso_smpl_q, miso_smpl_d;
    logic [GW-1:0]  gap_q, gap_d;
    logic [11:0]    res_q, res_d;
    logic           cmplt_q, cmplt_d;

    logic           rise, fall, frm_end;
    logic [15:0]    shft_nxt;

    assign rise     = !ss_n_q && (sclk_div_q == 5'b01111);
    assign fall     = !ss_n_q && (sclk_div_q == 5'b11111);
    assign frm_end  = fall && (bit_cnt_q == 5'd16);
    assign shft_nxt = {shft_q[14:0], miso_smpl_q};

    always_comb begin
        state_d     = state_q;
        ss_n_d      = ss_n_q;
        bit_cnt_d   = bit_cnt_q;
        shft_d      = shft_q;
        miso_smpl_d = miso_smpl_q;
        gap_d       = gap_q;
        res_d       = res_q;
        cmplt_d     = cmplt_q;
        sclk_div_d  = sclk_div_q;

        if (rise) begin
            miso_smpl_d = MISO;
            bit_cnt_d   = bit_cnt_q + 5'd1;
        end
        // The first fall of a frame must not shift, so bit 15 meets the first rise.
        if (fall && (bit_cnt_q != 5'd0)) begin
            shft_d = shft_nxt;
        end
        if (frm_end) begin
            ss_n_d    = 1'b1;
            bit_cnt_d = 5'd0;
        end

        case (state_q)
            IDLE: begin
                if (strt_cnv) begin
                    cmplt_d = 1'b0;
                    shft_d  = {2'b00, chnnl, 11'h000};
                    ss_n_d  = 1'b0;
                    state_d = FRM1;
                end
            end
            FRM1: begin
                if (frm_end) begin
                    gap_d   = '0;
                    state_d = GAP;
                end
            end
            GAP: begin
                gap_d = gap_q + GW'(1);
                if (gap_q == GW'(GAP_CLKS - 1)) begin
                    shft_d  = 16'h0000;
                    ss_n_d  = 1'b0;
                    state_d = FRM2;
                end
            end
            FRM2: begin
                if (frm_end) begin
                    res_d   = shft_nxt[11:0];
                    cmplt_d = 1'b1;
                    // Clearing here keeps MOSI low for the whole of IDLE.
                    shft_d  = 16'h0000;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Divider sits at the reload value while deselected and counts from the select edge.
        sclk_div_d = ss_n_d ? SCLK_RELOAD : (sclk_div_q + 5'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ss_n_q      <= 1'b1;
            sclk_div_q  <= SCLK_RELOAD;
            bit_cnt_q   <= 5'd0;
            shft_q      <= 16'h0000;
            miso_smpl_q <= 1'b0;
            gap_q       <= '0;
            res_q       <= 12'h000;
            cmplt_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            ss_n_q      <= ss_n_d;
            sclk_div_q  <= sclk_div_d;
            bit_cnt_q   <= bit_cnt_d;
            shft_q      <= shft_d;
            miso_smpl_q <= miso_smpl_d;
            gap_q       <= gap_d;
            res_q       <= res_d;
            cmplt_q     <= cmplt_d;
        end
    end

    assign a2d_SS_n  = ss_n_q;
    assign SCLK      = sclk_div_q[4];
    assign MOSI      = shft_q[15];
    assign res       = res_q;
    assign cnv_cmplt = cmplt_q;

endmodule
